// File: rtl/dram_arbiter.sv
// dram_arbiter: shares one synchronous data RAM port between the CPU memory
// stage (master 0) and a DMA/peripheral requester (master 1).
// Each transaction goes through three phases: the command is latched and
// granted, the RAM is driven for one cycle, and the owner is acknowledged
// while the RAM's registered read data is passed straight through.
// Optional build macro DRAM_ARB_CPU_PRIO_EN: master 0 wins every tie
// (fixed priority). Without it, ties alternate between the masters.
module dram_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_addr_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [DW-1:0]   m0_data_i,
  output logic            m0_gnt_o,
  output logic            m0_ack_o,
  input  logic            m1_req_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [DW-1:0]   m1_data_i,
  output logic            m1_gnt_o,
  output logic            m1_ack_o,
  output logic [DW-1:0]   rdata_o,
  output logic            stall_o,
  output logic            ram_ce_o,
  output logic            ram_we_o,
  output logic [AW-1:0]   ram_addr_o,
  output logic [DW/8-1:0] ram_sel_o,
  output logic [DW-1:0]   ram_data_o,
  input  logic [DW-1:0]   ram_data_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic              owner_reg, owner_next;
  logic              last_owner_reg, last_owner_next;
  logic              cmd_we_reg, cmd_we_next;
  logic [AW-1:0]     cmd_addr_reg, cmd_addr_next;
  logic [DW/8-1:0]   cmd_sel_reg, cmd_sel_next;
  logic [DW-1:0]     cmd_data_reg, cmd_data_next;
  logic [1:0]        gnt_reg, gnt_next;

  logic [1:0]        req_vec;
  logic [1:0]        ack_vec;
  logic              any_req;
  logic              win;
  logic              win_we;
  logic [AW-1:0]     win_addr;
  logic [DW/8-1:0]   win_sel;
  logic [DW-1:0]     win_data;
`ifndef DRAM_ARB_CPU_PRIO_EN
  logic              rr_ref;
`endif

  assign req_vec = {m1_req_i, m0_req_i};

  // Per-master acknowledge: the owner is acked for the whole RESP cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ack
      assign ack_vec[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
    end
  endgenerate

  // Pick a winner among the current requesters and select its command.
  always_comb begin
    any_req = |req_vec;
`ifndef DRAM_ARB_CPU_PRIO_EN
    // In RESP the finishing owner is the most recent one, even though the
    // last_owner register only catches up at the end of this cycle.
    rr_ref = (state_reg == RESP) ? owner_reg : last_owner_reg;
`endif
    if (req_vec == 2'b11) begin
`ifdef DRAM_ARB_CPU_PRIO_EN
      win = 1'b0;
`else
      win = ~rr_ref;
`endif
    end else begin
      win = req_vec[1];
    end
    win_we   = win ? m1_we_i   : m0_we_i;
    win_addr = win ? m1_addr_i : m0_addr_i;
    win_sel  = win ? m1_sel_i  : m0_sel_i;
    win_data = win ? m1_data_i : m0_data_i;
  end

  // Next-state logic: arbitrate in IDLE and RESP, always one RAM cycle.
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    cmd_we_next     = cmd_we_reg;
    cmd_addr_next   = cmd_addr_reg;
    cmd_sel_next    = cmd_sel_reg;
    cmd_data_next   = cmd_data_reg;
    gnt_next        = 2'b00;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next    = ACCESS;
          owner_next    = win;
          cmd_we_next   = win_we;
          cmd_addr_next = win_addr;
          cmd_sel_next  = win_sel;
          cmd_data_next = win_data;
          gnt_next[win] = 1'b1;
        end
      end
      ACCESS: begin
        state_next = RESP;
      end
      RESP: begin
        last_owner_next = owner_reg;
        if (any_req) begin
          state_next    = ACCESS;
          owner_next    = win;
          cmd_we_next   = win_we;
          cmd_addr_next = win_addr;
          cmd_sel_next  = win_sel;
          cmd_data_next = win_data;
          gnt_next[win] = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, ownership, command latch and registered grant pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b1;
      cmd_we_reg     <= 1'b0;
      cmd_addr_reg   <= '0;
      cmd_sel_reg    <= '0;
      cmd_data_reg   <= '0;
      gnt_reg        <= 2'b00;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      cmd_we_reg     <= cmd_we_next;
      cmd_addr_reg   <= cmd_addr_next;
      cmd_sel_reg    <= cmd_sel_next;
      cmd_data_reg   <= cmd_data_next;
      gnt_reg        <= gnt_next;
    end
  end

  // RAM is only enabled in ACCESS; address/sel/data always show the latch.
  assign ram_ce_o   = (state_reg == ACCESS);
  assign ram_we_o   = (state_reg == ACCESS) && cmd_we_reg;
  assign ram_addr_o = cmd_addr_reg;
  assign ram_sel_o  = cmd_sel_reg;
  assign ram_data_o = cmd_data_reg;

  assign m0_gnt_o = gnt_reg[0];
  assign m1_gnt_o = gnt_reg[1];
  assign m0_ack_o = ack_vec[0];
  assign m1_ack_o = ack_vec[1];

  // RAM output is already registered, so read data is a plain passthrough.
  assign rdata_o = ram_data_i;
  assign stall_o = m0_req_i & ~m0_ack_o;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed scenarios plus randomized traffic for
// dram_arbiter. A transaction-level model (grant rule, byte-merge memory)
// predicts grants, RAM strobes, acks and read data every cycle.
// Honours DRAM_ARB_CPU_PRIO_EN the same way as the design.
module tb_dram_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [31:0] m0_addr_i, m1_addr_i, m0_data_i, m1_data_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_gnt_o, m0_ack_o, m1_gnt_o, m1_ack_o;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        ram_ce_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
  logic [3:0]  ram_sel_o;

`ifdef DRAM_ARB_CPU_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  // Master command tables and progress.
  logic        cmd_we   [2][64];
  logic [31:0] cmd_addr [2][64];
  logic [3:0]  cmd_sel  [2][64];
  logic [31:0] cmd_data [2][64];
  int          cmd_gap  [2][64];
  int          iss      [2];
  int          n_cmd    [2];
  int          next_ok  [2];
  logic        out_q    [2];
  int          cyc;

  // Model state.
  logic [31:0] mdl_mem [int];
  logic        last_win;
  logic        lat_we;
  logic [31:0] lat_addr, lat_data;
  logic [3:0]  lat_sel;
  logic        dec_valid;
  logic [1:0]  dec_req;
  logic [1:0]  pend_ack;
  logic        pend_rd [2];
  logic [31:0] exp_rd  [2];
  logic        tx_we   [2];
  logic [31:0] tx_addr [2];
  logic [31:0] tx_data [2];
  logic [31:0] last_rd [2];
  int          acks_m  [2];
  logic        rst_drv, rst_q, rst_on_gnt;
  int          order_q[$];
  int          ack_cyc_q[$];
  int          n_checks, n_bad;

  // Bench RAM: no reset, registered read.
  logic [31:0] ram_mem [256];
  logic [31:0] ram_rd;
  assign ram_data_i = ram_rd;

  always @(posedge clk) begin
    if (ram_ce_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_sel_o[b]) ram_mem[ram_addr_o[9:2]][b*8 +: 8] <= ram_data_o[b*8 +: 8];
      end else begin
        ram_rd <= ram_mem[ram_addr_o[9:2]];
      end
    end
  end

  // Masters: hold req until gnt, then drop it combinationally on ack unless
  // the next command is already due.
  assign m0_req_i  = ((iss[0] < n_cmd[0]) && (cyc >= next_ok[0])) || (out_q[0] && !m0_ack_o);
  assign m1_req_i  = ((iss[1] < n_cmd[1]) && (cyc >= next_ok[1])) || (out_q[1] && !m1_ack_o);
  assign m0_we_i   = cmd_we[0][iss[0][5:0]];
  assign m0_addr_i = cmd_addr[0][iss[0][5:0]];
  assign m0_sel_i  = cmd_sel[0][iss[0][5:0]];
  assign m0_data_i = cmd_data[0][iss[0][5:0]];
  assign m1_we_i   = cmd_we[1][iss[1][5:0]];
  assign m1_addr_i = cmd_addr[1][iss[1][5:0]];
  assign m1_sel_i  = cmd_sel[1][iss[1][5:0]];
  assign m1_data_i = cmd_data[1][iss[1][5:0]];

  dram_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_sel_i(m0_sel_i), .m0_data_i(m0_data_i),
    .m0_gnt_o(m0_gnt_o), .m0_ack_o(m0_ack_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_sel_i(m1_sel_i), .m1_data_i(m1_data_i),
    .m1_gnt_o(m1_gnt_o), .m1_ack_o(m1_ack_o),
    .rdata_o(rdata_o), .stall_o(stall_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_sel_o(ram_sel_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic load(input int m, input int i, input logic we, input logic [31:0] ad,
                      input logic [3:0] s, input logic [31:0] d, input int gap);
    cmd_we[m][i]   = we;
    cmd_addr[m][i] = ad;
    cmd_sel[m][i]  = s;
    cmd_data[m][i] = d;
    cmd_gap[m][i]  = gap;
  endtask

  // Requests become visible only after the next negedge so that the model's
  // sampled request vector always matches what the DUT sees.
  task automatic start(input int m, input int n, input int off);
    iss[m]     = 0;
    n_cmd[m]   = n;
    next_ok[m] = cyc + 1 + off;
  endtask

  // One clock cycle: predict, compare, let masters react, drive next inputs.
  task automatic step();
    logic [1:0]  eg, g, a;
    logic        w, req0_now;
    logic [31:0] word;
    int          key;
    @(negedge clk);
    if (rst_q) begin
      lat_we = 1'b0; lat_addr = '0; lat_sel = '0; lat_data = '0;
      last_win = 1'b1;
    end
    eg = 2'b00;
    if (dec_valid && (dec_req != 2'b00)) begin
      if (dec_req == 2'b11) w = PRIO ? 1'b0 : ~last_win;
      else                  w = dec_req[1];
      eg[w]    = 1'b1;
      last_win = w;
      lat_we   = cmd_we[w][iss[w][5:0]];
      lat_addr = cmd_addr[w][iss[w][5:0]];
      lat_sel  = cmd_sel[w][iss[w][5:0]];
      lat_data = cmd_data[w][iss[w][5:0]];
      key  = int'(lat_addr[9:2]);
      word = mdl_mem.exists(key) ? mdl_mem[key] : 32'h0;
      if (lat_we) begin
        for (int b = 0; b < 4; b++)
          if (lat_sel[b]) word[b*8 +: 8] = lat_data[b*8 +: 8];
        mdl_mem[key] = word;
      end
      pend_rd[w] = !lat_we;
      exp_rd[w]  = word;
      tx_we[w]   = lat_we;
      tx_addr[w] = lat_addr;
      tx_data[w] = lat_data;
    end
    g = {m1_gnt_o, m0_gnt_o};
    a = {m1_ack_o, m0_ack_o};
    check("gnt", 32'(g), 32'(eg));
    check("ram_ce", 32'(ram_ce_o), 32'(|eg));
    check("ram_we", 32'(ram_we_o), 32'((|eg) & lat_we));
    check("ram_addr", ram_addr_o, lat_addr);
    check("ram_sel", 32'(ram_sel_o), 32'(lat_sel));
    check("ram_data", ram_data_o, lat_data);
    check("ack", 32'(a), 32'(pend_ack));
    for (int m = 0; m < 2; m++) begin
      if (pend_ack[m] && a[m]) begin
        if (pend_rd[m]) begin
          check("rdata", rdata_o, exp_rd[m]);
          last_rd[m] = rdata_o;
        end
        order_q.push_back(m);
        ack_cyc_q.push_back(cyc);
        acks_m[m]++;
        $display("tx m%0d %s addr=%08h data=%08h cyc=%0d", m, tx_we[m] ? "wr" : "rd",
                 tx_addr[m], tx_we[m] ? tx_data[m] : rdata_o, cyc);
      end
    end
    req0_now = ((iss[0] < n_cmd[0]) && (cyc >= next_ok[0])) || (out_q[0] && !pend_ack[0]);
    check("stall", 32'(stall_o), 32'(req0_now & ~pend_ack[0]));
    for (int m = 0; m < 2; m++) begin
      if (g[m]) begin
        next_ok[m] = cyc + 1 + cmd_gap[m][iss[m][5:0]];
        iss[m]++;
        out_q[m] = 1'b1;
      end
      if (a[m]) out_q[m] = 1'b0;
    end
    if (rst_on_gnt && (g != 2'b00)) begin
      rst_drv    = 1'b1;
      rst_on_gnt = 1'b0;
    end
    cyc++;
    rst   = rst_drv;
    rst_q = rst_drv;
    if (rst_drv) begin
      out_q[0] = 1'b0;
      out_q[1] = 1'b0;
    end
    pend_ack  = rst_drv ? 2'b00 : eg;
    dec_valid = (eg == 2'b00) && !rst_drv;
    for (int m = 0; m < 2; m++)
      dec_req[m] = ((iss[m] < n_cmd[m]) && (cyc >= next_ok[m])) || (out_q[m] && !a[m]);
  endtask

  function automatic bit all_done();
    return (iss[0] == n_cmd[0]) && (iss[1] == n_cmd[1]) && !out_q[0] && !out_q[1];
  endfunction

  task automatic run(input int budget);
    int c;
    c = 0;
    while (!all_done() && c < budget) begin
      step();
      c++;
    end
    check("timeout", 32'(all_done()), 32'd1);
    step();
    step();
  endtask

  task automatic do_reset(input int n);
    rst_drv = 1'b1;
    repeat (n) step();
    rst_drv = 1'b0;
  endtask

  initial begin
    int c0, acks_before;
    int exp_order [8];
    logic [31:0] ad;
    n_checks = 0; n_bad = 0; cyc = 0;
    rst = 1'b1; rst_drv = 1'b1; rst_q = 1'b1; rst_on_gnt = 1'b0;
    dec_valid = 1'b0; dec_req = 2'b00; pend_ack = 2'b00; last_win = 1'b1;
    lat_we = 1'b0; lat_addr = '0; lat_sel = '0; lat_data = '0;
    for (int m = 0; m < 2; m++) begin
      iss[m] = 0; n_cmd[m] = 0; next_ok[m] = 0; out_q[m] = 1'b0;
      pend_rd[m] = 1'b0; exp_rd[m] = '0; last_rd[m] = '0; acks_m[m] = 0;
      tx_we[m] = 1'b0; tx_addr[m] = '0; tx_data[m] = '0;
      for (int i = 0; i < 64; i++) load(m, i, 1'b0, 32'h0, 4'h0, 32'h0, 0);
    end
    for (int i = 0; i < 256; i++) ram_mem[i] = 32'h0;
    ram_rd = 32'h0;

    // Reset state, then 10 idle cycles.
    do_reset(3);
    repeat (10) step();

    // Single write then read.
    load(0, 0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1);
    load(0, 1, 1'b0, 32'h10, 4'hF, 32'h0, 0);
    start(0, 2, 0);
    run(50);
    check("rd_deadbeef", last_rd[0], 32'hDEADBEEF);

    // Byte write by m1, read back by m0.
    load(1, 0, 1'b1, 32'h20, 4'hF, 32'h11223344, 0);
    load(1, 1, 1'b1, 32'h20, 4'b0010, 32'h0000AB00, 0);
    start(1, 2, 0);
    run(50);
    load(0, 0, 1'b0, 32'h20, 4'hF, 32'h0, 0);
    start(0, 1, 0);
    run(50);
    check("rd_byte", last_rd[0], 32'h1122AB44);

    // Simultaneous continuous requests right after reset.
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      load(0, i, 1'b0, 32'h100 + 32'(i*4), 4'hF, 32'h0, 0);
      load(1, i, 1'b0, 32'h200 + 32'(i*4), 4'hF, 32'h0, 0);
    end
    order_q.delete();
    ack_cyc_q.delete();
    start(0, 4, 0);
    start(1, 4, 0);
    run(100);
    for (int i = 0; i < 8; i++) exp_order[i] = PRIO ? (i / 4) : (i % 2);
    for (int i = 0; i < 8; i++)
      check("order", (order_q.size() > i) ? 32'(order_q[i]) : 32'd99, 32'(exp_order[i]));
    for (int i = 1; i < 8; i++)
      check("ack_spacing", (ack_cyc_q.size() > i) ? 32'(ack_cyc_q[i] - ack_cyc_q[i-1]) : 32'd0, 32'd2);

    // Back-to-back reads from m0.
    for (int i = 0; i < 3; i++) load(0, i, 1'b0, 32'h10 + 32'(i*16), 4'hF, 32'h0, 0);
    ack_cyc_q.delete();
    c0 = cyc;
    start(0, 3, 0);
    run(50);
    for (int i = 0; i < 3; i++)
      check("b2b_ack_cyc", (ack_cyc_q.size() > i) ? 32'(ack_cyc_q[i] - c0) : 32'd0, 32'(2 + 2*i));

    // Reset asserted in the ACCESS cycle of an m1 write.
    load(1, 0, 1'b1, 32'h30, 4'hF, 32'h55, 0);
    acks_before = acks_m[1];
    rst_on_gnt = 1'b1;
    start(1, 1, 0);
    run(20);
    do_reset(2);
    step();
    check("no_ack_after_rst", 32'(acks_m[1] - acks_before), 32'd0);
    load(0, 0, 1'b0, 32'h30, 4'hF, 32'h0, 0);
    start(0, 1, 0);
    run(50);
    check("rd_after_rst", last_rd[0], 32'h55);

    // Randomized traffic from both masters.
    for (int r = 0; r < 3; r++) begin
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < 16; i++) begin
          ad = 32'($urandom_range(0, 255)) << 2;
          load(m, i, 1'($urandom_range(0, 1)), ad, 4'($urandom_range(0, 15)),
               $urandom, int'($urandom_range(0, 3)));
        end
      end
      start(0, 16, int'($urandom_range(0, 3)));
      start(1, 16, int'($urandom_range(0, 3)));
      run(1000);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
